hit_judge: RTL and testbench



---
 rtl/guitar_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 64 ++++++
 rtl/hit_judge.sv | 173 +++++++++++++++++
 tb/tb_hit_judge.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/guitar_pkg.sv
// Shared constants and types for the rhythm-game judging logic.
//   LANES_DEF      : number of note lanes / buttons (matches shifter row width)
//   SCORE_MAX_DEF  : score saturation value
//   MAX_MISSES_DEF : miss count that ends the game
//   MULT_CAP       : largest combo-derived bonus added to the base multiplier of 1
//   game_state_t   : IDLE (paused), PLAY (judging), OVER (terminal until reset)
package guitar_pkg;

    localparam int LANES_DEF      = 4;
    localparam int SCORE_MAX_DEF  = 9999;
    localparam int MAX_MISSES_DEF = 10;
    localparam int MULT_CAP       = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Single-lane button conditioner: 2-flop synchronizer followed by a debounce
// counter. The debounced level only flips after the synchronized input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   btn_raw    : asynchronous push-button input
//   level      : debounced button level
//   rise       : one-cycle pulse, high in the first cycle level reads 1
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;
    logic          rise_q,  rise_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            // Nth consecutive disagreeing cycle: accept the new level.
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/hit_judge.sv
// Judges debounced button presses against the note row sitting on the bottom
// line each time the shifter advances (enable low for one cycle = tick), and
// keeps score, combo, misses and game-over status.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : run enable shared with the shifter (0 = paused)
//   btn         : raw push buttons, bit i = lane i
//   check       : bottom row from the shifter, loaded on each tick
//   enable      : active-low row-advance tick from the shifter
//   score       : saturating score, 0..SCORE_MAX
//   combo       : consecutive correctly hit rows, saturating at 255
//   misses      : missed note rows, saturating at 255
//   hit_pulse   : one cycle after a tick that judged a correct row
//   miss_pulse  : one cycle after a tick that judged a missed row
//   game_over   : high once misses reach MAX_MISSES
//   press_mask  : lanes pressed in the current window
module hit_judge
    import guitar_pkg::*;
#(
    parameter int LANES           = LANES_DEF,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int MAX_MISSES      = MAX_MISSES_DEF,
    parameter int SCORE_MAX       = SCORE_MAX_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LANES-1:0] btn,
    input  logic [LANES-1:0] check,
    input  logic             enable,
    output logic [13:0]      score,
    output logic [7:0]       combo,
    output logic [7:0]       misses,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic             game_over,
    output logic [LANES-1:0] press_mask
);

    game_state_t      state_q, state_d;
    logic [13:0]      score_q, score_d;
    logic [7:0]       combo_q, combo_d;
    logic [7:0]       misses_q, misses_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;
    logic [LANES-1:0] judged_row_q, judged_row_d;
    logic [LANES-1:0] press_mask_q, press_mask_d;

    logic [LANES-1:0] btn_level;
    logic [LANES-1:0] btn_rise;
    logic             tick;
    logic [2:0]       mult;
    logic [14:0]      score_sum;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn[i]),
            .level  (btn_level[i]),
            .rise   (btn_rise[i])
        );
    end

    assign tick = ~enable;

    // Combo-driven multiplier: 1 + min(combo/8, MULT_CAP).
    always_comb begin
        if (combo_q[7:3] > 5'(MULT_CAP)) begin
            mult = 3'(MULT_CAP + 1);
        end else begin
            mult = 3'(combo_q[7:3]) + 3'd1;
        end
        score_sum = {1'b0, score_q} + 15'(mult);
    end

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        combo_d      = combo_q;
        misses_d     = misses_q;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        judged_row_d = judged_row_q;
        // Window closes on a tick; an edge landing in the tick cycle belongs
        // to the new window, hence the OR after the clear.
        press_mask_d = (tick ? '0 : press_mask_q) | btn_rise;

        // Track the shifter's bottom row on every tick so the window stays
        // aligned with the display even while paused.
        if (tick) begin
            judged_row_d = check;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (judged_row_q != '0) begin
                        if (press_mask_q == judged_row_q) begin
                            if (score_sum >= 15'(SCORE_MAX)) begin
                                score_d = 14'(SCORE_MAX);
                            end else begin
                                score_d = score_sum[13:0];
                            end
                            if (combo_q != 8'hFF) begin
                                combo_d = combo_q + 8'd1;
                            end
                            hit_d = 1'b1;
                        end else begin
                            if (misses_q != 8'hFF) begin
                                misses_d = misses_q + 8'd1;
                            end
                            combo_d = '0;
                            miss_d  = 1'b1;
                        end
                    end else if (press_mask_q != '0) begin
                        // Pressing on an empty row breaks the streak only.
                        combo_d = '0;
                    end
                end
                if (misses_d >= 8'(MAX_MISSES)) begin
                    state_d = OVER;
                end else if (!start) begin
                    state_d = IDLE;
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            score_q      <= '0;
            combo_q      <= '0;
            misses_q     <= '0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            judged_row_q <= '0;
            press_mask_q <= '0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            combo_q      <= combo_d;
            misses_q     <= misses_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            judged_row_q <= judged_row_d;
            press_mask_q <= press_mask_d;
        end
    end

    assign score      = score_q;
    assign combo      = combo_q;
    assign misses     = misses_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign game_over  = (state_q == OVER);
    assign press_mask = press_mask_q;

endmodule

// File: tb/tb_hit_judge.sv
module tb_hit_judge;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  btn;
    logic [3:0]  check;
    logic        enable;
    logic [13:0] score;
    logic [7:0]  combo;
    logic [7:0]  misses;
    logic        hit_pulse;
    logic        miss_pulse;
    logic        game_over;
    logic [3:0]  press_mask;

    int errors = 0;
    int checks = 0;

    hit_judge #(
        .LANES(4), .DEBOUNCE_CYCLES(4), .MAX_MISSES(3), .SCORE_MAX(9999)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .btn(btn), .check(check),
        .enable(enable), .score(score), .combo(combo), .misses(misses),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over),
        .press_mask(press_mask)
    );

    always #5 clk = ~clk;

    // One-cycle tick loading row; returns at the negedge where the judgement is visible.
    task automatic do_tick(input logic [3:0] row);
        @(negedge clk);
        enable = 1'b0;
        check  = row;
        @(negedge clk);
        enable = 1'b1;
    endtask

    // Clean press and release of the given lanes.
    task automatic press(input logic [3:0] m);
        @(negedge clk);
        btn = m;
        repeat (10) @(negedge clk);
        btn = 4'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset;
        start = 1'b1; btn = 4'hF; check = 4'b0; enable = 1'b1; reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({score, combo, misses, hit_pulse, miss_pulse, game_over, press_mask} !== 37'b0) begin
            errors++;
            $display("FAIL reset_outputs: got score=%0d combo=%0d misses=%0d hit=%b miss=%b over=%b mask=%b, want all 0",
                     score, combo, misses, hit_pulse, miss_pulse, game_over, press_mask);
        end
        btn = 4'b0; reset = 1'b0;
        repeat (2) @(negedge clk);
        do_tick(4'b0101);
        checks++;
        if ({hit_pulse, miss_pulse, score, combo} !== 24'b0) begin
            errors++;
            $display("FAIL first_tick_empty: got hit=%b miss=%b score=%0d combo=%0d, want 0 0 0 0",
                     hit_pulse, miss_pulse, score, combo);
        end
    endtask

    task automatic test_hit;
        press(4'b0101);
        checks++;
        if (press_mask !== 4'b0101) begin
            errors++; $display("FAIL press_mask_set: got %b want 0101", press_mask);
        end
        do_tick(4'b0011);
        checks++;
        if ({hit_pulse, miss_pulse} !== 2'b10 || score !== 14'd1 || combo !== 8'd1) begin
            errors++;
            $display("FAIL first_hit: got hit=%b miss=%b score=%0d combo=%0d, want 1 0 1 1",
                     hit_pulse, miss_pulse, score, combo);
        end
        checks++;
        if (press_mask !== 4'b0) begin
            errors++; $display("FAIL mask_cleared_on_tick: got %b want 0000", press_mask);
        end
        @(negedge clk);
        checks++;
        if (hit_pulse !== 1'b0) begin
            errors++; $display("FAIL hit_pulse_width: got %b want 0", hit_pulse);
        end
    endtask

    task automatic test_miss;
        press(4'b0001);
        do_tick(4'b1000);
        checks++;
        if ({hit_pulse, miss_pulse} !== 2'b01 || misses !== 8'd1 || combo !== 8'd0 || score !== 14'd1) begin
            errors++;
            $display("FAIL partial_press_miss: got hit=%b miss=%b misses=%0d combo=%0d score=%0d, want 0 1 1 0 1",
                     hit_pulse, miss_pulse, misses, combo, score);
        end
    endtask

    task automatic test_combo;
        for (int i = 0; i < 9; i++) begin
            press(4'b1000);
            do_tick((i == 8) ? 4'b0000 : 4'b1000);
            if (i < 8) begin
                checks++;
                if (hit_pulse !== 1'b1 || score !== 14'(2 + i) || combo !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL combo_row_%0d: got hit=%b score=%0d combo=%0d, want 1 %0d %0d",
                             i, hit_pulse, score, combo, 2 + i, i + 1);
                end
            end
        end
        // combo was 8 before the 9th hit -> multiplier 2: 9 + 2 = 11
        checks++;
        if (hit_pulse !== 1'b1 || score !== 14'd11 || combo !== 8'd9) begin
            errors++;
            $display("FAIL combo_multiplier: got hit=%b score=%0d combo=%0d, want 1 11 9",
                     hit_pulse, score, combo);
        end
    endtask

    task automatic test_glitch;
        @(negedge clk);
        btn = 4'b0010;
        repeat (2) @(negedge clk);
        btn = 4'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (press_mask !== 4'b0) begin
            errors++; $display("FAIL glitch_filtered: got mask=%b want 0000", press_mask);
        end
        press(4'b1000);
        do_tick(4'b0000);
        checks++;
        if ({hit_pulse, miss_pulse} !== 2'b00 || combo !== 8'd0 || misses !== 8'd1 || score !== 14'd11) begin
            errors++;
            $display("FAIL wrong_press_empty_row: got hit=%b miss=%b combo=%0d misses=%0d score=%0d, want 0 0 0 1 11",
                     hit_pulse, miss_pulse, combo, misses, score);
        end
    endtask

    task automatic test_hold;
        @(negedge clk);
        btn = 4'b0100;
        repeat (10) @(negedge clk);
        do_tick(4'b0000);
        repeat (5) @(negedge clk);
        checks++;
        if (press_mask !== 4'b0) begin
            errors++; $display("FAIL held_button_no_reset: got mask=%b want 0000", press_mask);
        end
        btn = 4'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_pause;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        press(4'b0001);
        do_tick(4'b0000);
        checks++;
        if ({hit_pulse, miss_pulse, press_mask} !== 6'b0 || score !== 14'd11 || misses !== 8'd1) begin
            errors++;
            $display("FAIL paused_tick_ignored: got hit=%b miss=%b mask=%b score=%0d misses=%0d, want 0 0 0000 11 1",
                     hit_pulse, miss_pulse, press_mask, score, misses);
        end
        start = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        do_tick(4'b0001);
        press(4'b0001);
        @(negedge clk);
        enable = 1'b0;
        check  = 4'b0010;
        @(negedge clk);
        checks++;
        if ({hit_pulse, miss_pulse} !== 2'b10 || score !== 14'd12 || combo !== 8'd1) begin
            errors++;
            $display("FAIL b2b_first: got hit=%b miss=%b score=%0d combo=%0d, want 1 0 12 1",
                     hit_pulse, miss_pulse, score, combo);
        end
        check = 4'b0100;
        @(negedge clk);
        enable = 1'b1;
        checks++;
        if ({hit_pulse, miss_pulse} !== 2'b01 || misses !== 8'd2 || combo !== 8'd0) begin
            errors++;
            $display("FAIL b2b_second: got hit=%b miss=%b misses=%0d combo=%0d, want 0 1 2 0",
                     hit_pulse, miss_pulse, misses, combo);
        end
    endtask

    task automatic test_game_over;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        do_tick(4'b0001);
        for (int i = 1; i <= 3; i++) begin
            do_tick(4'b0001);
            checks++;
            if (miss_pulse !== 1'b1 || misses !== 8'(i) || game_over !== (i == 3)) begin
                errors++;
                $display("FAIL over_miss_%0d: got miss=%b misses=%0d over=%b, want 1 %0d %b",
                         i, miss_pulse, misses, game_over, i, (i == 3));
            end
        end
        press(4'b0001);
        do_tick(4'b0001);
        checks++;
        if ({hit_pulse, miss_pulse} !== 2'b00 || misses !== 8'd3 || score !== 14'd0 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL over_frozen: got hit=%b miss=%b misses=%0d score=%0d over=%b, want 0 0 3 0 1",
                     hit_pulse, miss_pulse, misses, score, game_over);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({score, combo, misses, hit_pulse, miss_pulse, game_over, press_mask} !== 37'b0) begin
            errors++;
            $display("FAIL over_reset: got score=%0d combo=%0d misses=%0d over=%b mask=%b, want all 0",
                     score, combo, misses, game_over, press_mask);
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_combo();
        test_glitch();
        test_hold();
        test_pause();
        test_back_to_back();
        test_game_over();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
